// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter
//   Single-port text/glyph memory arbiter and fetch sequencer for the VGA text
//   pipeline. Each 8-pixel cell runs a fixed slot schedule. When the cell needs
//   a video fetch (fe_q), phases 0..3 fetch the next cell's character word and
//   glyph row, and the CPU may issue only in phases 4 and 6. Otherwise the CPU
//   may issue in any phase.
//
// Ports
//   clk, rst_n        pixel clock; asynchronous active-low reset
//   pixel_counter     pixel column; phase = pixel_counter[2:0]
//   vid_fetch_en      next cell needs a fetch (captured at the end of phase 7)
//   vid_char_addr     character-word address (phase 0)
//   vid_glyph_addr    glyph-row address (phase 2)
//   glyph_code        character code of the cell being fetched
//   cell_attr         attribute of the displayed cell
//   cell_glyph_bits   glyph row of the displayed cell
//   mem_addr/we/wdata combinational memory request
//   mem_rdata         synchronous read data (one cycle after the address)
//   cpu_req/we/addr/wdata  CPU request, held stable until cpu_ack
//   cpu_ack           one-cycle completion pulse
//   cpu_rdata         read data, valid in the ack cycle and held afterwards
module vga_mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  pixel_counter,
    input  logic        vid_fetch_en,
    input  logic [15:0] vid_char_addr,
    input  logic [15:0] vid_glyph_addr,
    output logic [7:0]  glyph_code,
    output logic [7:0]  cell_attr,
    output logic [15:0] cell_glyph_bits,
    output logic [15:0] mem_addr,
    output logic        mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [15:0] cpu_rdata
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]  state;
    logic        fe_q;
    logic        we_q;
    logic [2:0]  phase;
    logic [7:0]  attr_next;
    logic [15:0] bits_next;
    logic [15:0] rdata_q;
    logic        vid_char_slot;
    logic        vid_glyph_slot;
    logic        cpu_slot;
    logic        issue;
    logic        unused_pixel_hi;

    assign unused_pixel_hi = ^pixel_counter[9:3];

    always_comb begin
        phase          = pixel_counter[2:0];
        vid_char_slot  = fe_q && (phase == 3'd0);
        vid_glyph_slot = fe_q && (phase == 3'd2);
        cpu_slot       = !fe_q || (phase == 3'd4) || (phase == 3'd6);
        // rst_n in the issue term keeps mem_we low combinationally during reset;
        // being in IDLE already guarantees no issue in an ack cycle.
        issue          = rst_n && (state == ST_IDLE) && cpu_req && cpu_slot;
    end

    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (vid_char_slot) begin
            mem_addr = vid_char_addr;
        end else if (vid_glyph_slot) begin
            mem_addr = vid_glyph_addr;
        end else if (issue) begin
            mem_addr  = cpu_addr;
            mem_we    = cpu_we;
            mem_wdata = cpu_wdata;
        end
    end

    // Read data arrives in the ack cycle, so it is passed straight through
    // there and held from the register afterwards.
    always_comb begin
        cpu_ack   = (state == ST_BUSY);
        cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (issue) begin
                        state <= ST_BUSY;
                        we_q  <= cpu_we;
                    end
                end
                default: begin
                    if (!we_q) begin
                        rdata_q <= mem_rdata;
                    end
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fe_q            <= 1'b0;
            glyph_code      <= '0;
            attr_next       <= '0;
            bits_next       <= '0;
            cell_attr       <= '0;
            cell_glyph_bits <= '0;
        end else begin
            if (fe_q && (phase == 3'd1)) begin
                glyph_code <= mem_rdata[15:8];
                attr_next  <= mem_rdata[7:0];
            end
            if (fe_q && (phase == 3'd3)) begin
                bits_next <= mem_rdata;
            end
            // Commit is unconditional: without a fetch the staged values are
            // unchanged, which re-presents the previous cell.
            if (phase == 3'd7) begin
                fe_q            <= vid_fetch_en;
                cell_attr       <= attr_next;
                cell_glyph_bits <= bits_next;
            end
        end
    end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
module tb_vga_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  pixel_counter;
    logic        vid_fetch_en;
    logic [15:0] vid_char_addr;
    logic [15:0] vid_glyph_addr;
    logic [7:0]  glyph_code;
    logic [7:0]  cell_attr;
    logic [15:0] cell_glyph_bits;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;

    vga_mem_arbiter dut (
        .clk(clk), .rst_n(rst_n), .pixel_counter(pixel_counter),
        .vid_fetch_en(vid_fetch_en), .vid_char_addr(vid_char_addr),
        .vid_glyph_addr(vid_glyph_addr), .glyph_code(glyph_code),
        .cell_attr(cell_attr), .cell_glyph_bits(cell_glyph_bits),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata)
    );

    always #5 clk = ~clk;

    // Shared synchronous BRAM: address sampled at the edge, data next cycle.
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model state (spec-level: cell fetch flag, staged and shown cell,
    // outstanding CPU transaction).
    logic        fe_m;
    logic [7:0]  disp_attr, nxt_attr;
    logic [15:0] disp_bits, nxt_bits;
    logic [15:0] exp_char;
    logic        exp_ack, issue_now, exp_read;
    logic [15:0] exp_rd, last_rd;
    int          req_cyc;

    function automatic logic [15:0] pick_addr();
        return ($urandom_range(0, 4) == 0) ? 16'h1234 : 16'($urandom_range(0, 63));
    endfunction

    task automatic cycle();
        logic [2:0] ph_prev;
        logic [2:0] ph;
        logic       exp_issue;
        ph_prev = pixel_counter[2:0];
        @(posedge clk);
        cyc++;
        if (ph_prev == 3'd7) begin
            disp_attr = nxt_attr;
            disp_bits = nxt_bits;
            fe_m      = vid_fetch_en;
        end
        if (exp_ack) begin
            exp_ack = 1'b0;
            cpu_req = 1'b0;
        end
        if (issue_now) begin
            exp_ack   = 1'b1;
            issue_now = 1'b0;
        end
        #1;
        pixel_counter = (pixel_counter == 10'd799) ? 10'd0 : pixel_counter + 10'd1;
        vid_fetch_en  = ($urandom_range(0, 3) != 0);
        if (cyc > 8 && pixel_counter[2:0] == 3'd0) vid_char_addr  = pick_addr();
        if (cyc > 8 && pixel_counter[2:0] == 3'd2) vid_glyph_addr = pick_addr();
        if (!cpu_req && $urandom_range(0, 2) == 0) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = pick_addr();
            cpu_wdata = 16'($urandom);
            req_cyc   = cyc;
        end
        @(negedge clk);
        ph = pixel_counter[2:0];

        check_eq("ack", cpu_ack, exp_ack);
        if (exp_ack) check_eq("latency", (cyc - req_cyc) <= 6, 1);
        if (exp_ack && exp_read) begin
            check_eq("rd_data", cpu_rdata, exp_rd);
            last_rd = exp_rd;
        end else begin
            check_eq("rd_hold", cpu_rdata, last_rd);
        end

        exp_issue = cpu_req && !exp_ack && (!fe_m || ph == 3'd4 || ph == 3'd6);
        if (exp_issue) begin
            check_eq("cpu_addr", mem_addr, cpu_addr);
            check_eq("cpu_we", mem_we, cpu_we);
            if (cpu_we) check_eq("cpu_wdata", mem_wdata, cpu_wdata);
            issue_now = 1'b1;
            exp_read  = !cpu_we;
            exp_rd    = mem[cpu_addr];
        end else begin
            check_eq("we_idle", mem_we, 0);
            check_eq("wdata_idle", mem_wdata, 0);
            if (fe_m && ph == 3'd0) begin
                check_eq("vid_char", mem_addr, vid_char_addr);
                exp_char = mem[vid_char_addr];
            end else if (fe_m && ph == 3'd2) begin
                check_eq("vid_glyph", mem_addr, vid_glyph_addr);
                check_eq("glyph_code", glyph_code, exp_char[15:8]);
                nxt_attr = exp_char[7:0];
                nxt_bits = mem[vid_glyph_addr];
            end else begin
                check_eq("addr_idle", mem_addr, 0);
            end
        end
        if (ph == 3'd0) begin
            check_eq("cell_attr", cell_attr, disp_attr);
            check_eq("cell_bits", cell_glyph_bits, disp_bits);
        end
    endtask

    initial begin
        int acks;
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i * 40503 + 17);
        mem[16'h0010] = 16'h4107;
        mem[16'h2208] = 16'hA5F0;
        mem[16'h1234] = 16'hBEEF;

        // Reset with a write request pending: nothing may reach memory.
        rst_n = 1'b0; pixel_counter = '0; vid_fetch_en = 1'b0;
        vid_char_addr = '0; vid_glyph_addr = '0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0050; cpu_wdata = 16'hDEAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_we", mem_we, 0);
        check_eq("rst_ack", cpu_ack, 0);
        check_eq("rst_glyph", glyph_code, 0);
        check_eq("rst_attr", cell_attr, 0);
        check_eq("rst_bits", cell_glyph_bits, 0);
        check_eq("rst_rdata", cpu_rdata, 0);

        // Read issued, then reset during its BUSY cycle: dropped, then reissued.
        cpu_we = 1'b0; cpu_addr = 16'h1234;
        @(posedge clk); #1 rst_n = 1'b1; pixel_counter = 10'd1;
        @(negedge clk);
        check_eq("rel_issue", mem_addr, 16'h1234);
        @(posedge clk); #1 rst_n = 1'b0; pixel_counter = 10'd2;
        @(negedge clk);
        check_eq("rst_busy_ack", cpu_ack, 0);
        @(posedge clk); #1 rst_n = 1'b1; pixel_counter = 10'd3;
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                acks++;
                check_eq("reissue_rd", cpu_rdata, 16'hBEEF);
            end
            @(posedge clk); #1;
            if (acks != 0) cpu_req = 1'b0;
            pixel_counter = pixel_counter + 10'd1;
        end
        check_eq("reissue_cnt", acks, 1);

        // Fresh start for the randomized run, first cell fetching the known vector.
        rst_n = 1'b0; cpu_req = 1'b0;
        pixel_counter = 10'd7; vid_fetch_en = 1'b1;
        vid_char_addr = 16'h0010; vid_glyph_addr = 16'h2208;
        fe_m = 1'b0; disp_attr = '0; nxt_attr = '0; disp_bits = '0; nxt_bits = '0;
        exp_char = '0; exp_ack = 1'b0; issue_now = 1'b0; exp_read = 1'b0;
        exp_rd = '0; last_rd = '0; req_cyc = 0; cyc = 0;
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (cyc == 9) begin
                check_eq("vec_attr", cell_attr, 8'h07);
                check_eq("vec_bits", cell_glyph_bits, 16'hA5F0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
